// File: rtl/mc_pkg.sv
// Shared constants, types and helpers for the 16x16 motion-compensated predictor.
// The reconstruction helper only exists when MC_RECON_EN is defined.
package mc_pkg;

  localparam int BLK_SIZE   = 16;
  localparam int DEF_BASE_X = 100;
  localparam int DEF_BASE_Y = 100;
  localparam int PIX_W      = 8;
  localparam int MV_W       = 6;
  localparam int ADDR_W     = 12;
  localparam int POS_W      = $clog2(BLK_SIZE);
  localparam int RES_W      = 9;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(BLK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             last;
  } pix_entry_t;

`ifdef MC_RECON_EN
  // Prediction plus signed residual, saturated to the 8-bit pixel range.
  function automatic logic [PIX_W-1:0] recon_clip(input logic [PIX_W-1:0] pix,
                                                  input logic signed [RES_W-1:0] res);
    logic signed [RES_W+1:0] sum;
    sum = $signed({3'b000, pix}) + $signed({{2{res[RES_W-1]}}, res});
    if (sum < 11'sd0)   return '0;
    if (sum > 11'sd255) return '1;
    return sum[PIX_W-1:0];
  endfunction
`endif

endpackage

// File: rtl/mc_pred_if.sv
// Reference-memory read bus and predicted-pixel stream of mc_pred.
// With MC_RECON_EN defined the bus also carries the residual i_res.
interface mc_pred_if;
  import mc_pkg::*;

  logic                    o_ref_rd;
  logic [ADDR_W-1:0]       o_ref_x;
  logic [ADDR_W-1:0]       o_ref_y;
  logic [PIX_W-1:0]        i_ref_pixel;
`ifdef MC_RECON_EN
  logic signed [RES_W-1:0] i_res;
`endif

  logic                    o_pix_valid;
  logic                    i_pix_ready;
  logic [PIX_W-1:0]        o_pix_data;
  logic [POS_W-1:0]        o_pix_x;
  logic [POS_W-1:0]        o_pix_y;
  logic                    o_pix_last;

  modport master (
    output o_ref_rd, o_ref_x, o_ref_y,
    output o_pix_valid, o_pix_data, o_pix_x, o_pix_y, o_pix_last,
`ifdef MC_RECON_EN
    input  i_res,
`endif
    input  i_ref_pixel, i_pix_ready
  );

  modport slave (
    input  o_ref_rd, o_ref_x, o_ref_y,
    input  o_pix_valid, o_pix_data, o_pix_x, o_pix_y, o_pix_last,
`ifdef MC_RECON_EN
    output i_res,
`endif
    output i_ref_pixel, i_pix_ready
  );

endinterface

// File: rtl/mc_pix_fifo.sv
// Two-entry FIFO of returned pixels tagged with block position and last flag.
// The caller guarantees no push while full; a pop while empty is ignored.
module mc_pix_fifo
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  pix_entry_t push_entry,
  input  logic       pop,
  output pix_entry_t head,
  output logic [1:0] count
);

  pix_entry_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_pop;

  assign do_pop = pop && (count != 2'd0);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mc_pred.sv
// Builds one 16x16 prediction block by raster reads from reference memory.
// Define MC_RECON_EN to add the residual input and clipped reconstruction.
module mc_pred
  import mc_pkg::*;
#(
  parameter int BASE_X = DEF_BASE_X,
  parameter int BASE_Y = DEF_BASE_Y
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic signed [MV_W-1:0] i_mv_x,
  input  logic signed [MV_W-1:0] i_mv_y,
  output logic                   o_busy,
  output logic                   o_done,
  mc_pred_if.master              bus
);

  state_t                 state;
  logic signed [MV_W-1:0] mv_x;
  logic signed [MV_W-1:0] mv_y;
  logic [POS_W-1:0]       cnt_x;
  logic [POS_W-1:0]       cnt_y;
  logic [POS_W-1:0]       tag_x;
  logic [POS_W-1:0]       tag_y;
  logic                   inflight;
  logic                   last_acc;

  logic [1:0]             fifo_count;
  logic                   pix_valid;
  logic                   pop;
  logic                   rd_issue;
  logic [2:0]             occupancy;
  logic [2:0]             limit;
  logic [ADDR_W-1:0]      addr_x;
  logic [ADDR_W-1:0]      addr_y;
  pix_entry_t             push_entry;
  pix_entry_t             head;

  // Reads return after exactly one cycle, so one in-flight bit is enough;
  // a read is allowed only if its data is sure to find a free FIFO slot.
  assign pix_valid = (fifo_count != 2'd0);
  assign pop       = pix_valid & bus.i_pix_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  assign limit     = 3'd2 + {2'b00, pop};
  assign rd_issue  = (state == FETCH) && (occupancy < limit);

  assign addr_x = ADDR_W'(BASE_X) + {{(ADDR_W-MV_W){mv_x[MV_W-1]}}, mv_x}
                + {{(ADDR_W-POS_W){1'b0}}, cnt_x};
  assign addr_y = ADDR_W'(BASE_Y) + {{(ADDR_W-MV_W){mv_y[MV_W-1]}}, mv_y}
                + {{(ADDR_W-POS_W){1'b0}}, cnt_y};

  always_comb begin
    // NOTE: full default first so no path leaves a field unassigned (no latch).
    push_entry      = '0;
    push_entry.x    = tag_x;
    push_entry.y    = tag_y;
    push_entry.last = (tag_x == POS_MAX) && (tag_y == POS_MAX);
`ifdef MC_RECON_EN
    push_entry.data = recon_clip(bus.i_ref_pixel, bus.i_res);
`else
    push_entry.data = bus.i_ref_pixel;
`endif
  end

  mc_pix_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      mv_x     <= '0;
      mv_y     <= '0;
      cnt_x    <= '0;
      cnt_y    <= '0;
      tag_x    <= '0;
      tag_y    <= '0;
      inflight <= 1'b0;
      last_acc <= 1'b0;
    end else begin
      o_done   <= 1'b0;
      inflight <= rd_issue;
      if (rd_issue) begin
        tag_x <= cnt_x;
        tag_y <= cnt_y;
      end
      if (pop && head.last) last_acc <= 1'b1;

      case (state)
        IDLE: begin
          if (i_start) begin
            mv_x     <= i_mv_x;
            mv_y     <= i_mv_y;
            cnt_x    <= '0;
            cnt_y    <= '0;
            last_acc <= 1'b0;
            o_busy   <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (rd_issue) begin
            cnt_x <= cnt_x + POS_W'(1);
            if (cnt_x == POS_MAX) begin
              cnt_y <= cnt_y + POS_W'(1);
              if (cnt_y == POS_MAX) state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if ((fifo_count == 2'd0) && !inflight && last_acc) begin
            o_done <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ref_rd    = rd_issue;
  assign bus.o_ref_x     = rd_issue ? addr_x : '0;
  assign bus.o_ref_y     = rd_issue ? addr_y : '0;
  assign bus.o_pix_valid = pix_valid;
  assign bus.o_pix_data  = pix_valid ? head.data : '0;
  assign bus.o_pix_x     = pix_valid ? head.x    : '0;
  assign bus.o_pix_y     = pix_valid ? head.y    : '0;
  assign bus.o_pix_last  = pix_valid & head.last;

endmodule
